// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding, colour helpers and geometry defaults.
// Colour-bar helpers are used only when CAM_TEST_PATT_EN is defined.
package cam_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_WAIT_FS,
    ST_ACTIVE
  } cam_state_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic logic [23:0] rgb565_to_888(
    input logic [15:0] p
  );
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = p[15:11];
    g = p[10:5];
    b = p[4:0];
    return {r, r[4:2], g, g[5:4], b, b[4:2]};
  endfunction

  function automatic logic [23:0] bar_color(
    input logic [2:0] idx
  );
    logic [23:0] c;
    unique case (idx)
      3'd0: c = BAR_WHITE;
      3'd1: c = BAR_YELLOW;
      3'd2: c = BAR_CYAN;
      3'd3: c = BAR_GREEN;
      3'd4: c = BAR_MAGENTA;
      3'd5: c = BAR_RED;
      3'd6: c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: 2-flop synchronizer for the 11-bit DVP pin bundle
// plus edge detect on the synchronized pclk, href and vsync.
module cam_sync_edge
  import cam_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pclk_i,
  input  logic       vsync_i,
  input  logic       href_i,
  input  logic [7:0] data_i,
  output logic       vsync_o,
  output logic       href_o,
  output logic [7:0] data_o,
  output logic       pclk_rise,
  output logic       href_fall,
  output logic       vsync_rise,
  output logic       vsync_fall
);

  logic [10:0] s1_q, s1_d;
  logic [10:0] s2_q, s2_d;
  // {pclk, vsync, href} one cycle behind s2
  logic [2:0]  prev_q, prev_d;

  always_comb begin
    s1_d   = {pclk_i, vsync_i, href_i, data_i};
    s2_d   = s1_q;
    prev_d = s2_q[10:8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign vsync_o    = s2_q[9];
  assign href_o     = s2_q[8];
  assign data_o     = s2_q[7:0];
  assign pclk_rise  = s2_q[10] & ~prev_q[2];
  assign vsync_rise = s2_q[9] & ~prev_q[1];
  assign vsync_fall = ~s2_q[9] & prev_q[1];
  assign href_fall  = ~s2_q[8] & prev_q[0];

endmodule

// File: rtl/cam_dvp_rx.sv
// cam_dvp_rx: one-shot DVP RGB565 frame capture into RGB888 writes.
// Define CAM_TEST_PATT_EN to add tpat_sel and colour-bar substitution.
module cam_dvp_rx
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned ADDR_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_req,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
`ifdef CAM_TEST_PATT_EN
  input  logic              tpat_sel,
`endif
  output logic              wr_en,
  input  logic              wr_rdy,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              ovf,
  output logic              err
);

  localparam logic [15:0] H_LIM = 16'(H_ACTIVE);
  localparam logic [15:0] V_LIM = 16'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ADDR_BASE);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  logic       s_vsync, s_href;
  logic [7:0] s_data;
  logic       pclk_rise, href_fall;
  logic       vs_rise, vs_fall;

  cam_sync_edge u_sync (
    .clk        (clk),
    .reset      (reset),
    .pclk_i     (cam_pclk),
    .vsync_i    (cam_vsync),
    .href_i     (cam_href),
    .data_i     (cam_data),
    .vsync_o    (s_vsync),
    .href_o     (s_href),
    .data_o     (s_data),
    .pclk_rise  (pclk_rise),
    .href_fall  (href_fall),
    .vsync_rise (vs_rise),
    .vsync_fall (vs_fall)
  );

  cam_state_e state_q, state_d;

  logic [15:0]       x_q, x_d;
  logic [15:0]       y_q, y_d;
  logic              ph_q, ph_d;
  logic [7:0]        b0_q, b0_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic              px_vld_q, px_vld_d;
  logic [23:0]       px_data_q, px_data_d;
  logic [ADDR_W-1:0] px_addr_q, px_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic        in_range;
  logic [23:0] pix;

`ifdef CAM_TEST_PATT_EN
  localparam logic [15:0] BAR_W =
    (H_ACTIVE / 8 == 0) ? 16'd1 : 16'(H_ACTIVE / 8);
  logic [15:0] bar_idx;
  logic [2:0]  bar_sel;

  always_comb begin
    bar_idx = x_q / BAR_W;
    bar_sel = (bar_idx > 16'd7) ? 3'd7 : bar_idx[2:0];
    pix = tpat_sel ? bar_color(bar_sel)
                   : rgb565_to_888({b0_q, s_data});
  end
`else
  always_comb begin
    pix = rgb565_to_888({b0_q, s_data});
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (cap_req) state_d = ST_WAIT_VS;
      ST_WAIT_VS: if (s_vsync) state_d = ST_WAIT_FS;
      ST_WAIT_FS: if (vs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE:  if (vs_rise) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    ph_d      = ph_q;
    b0_d      = b0_q;
    addr_d    = addr_q;
    line_d    = line_q;
    px_vld_d  = 1'b0;
    px_data_d = px_data_q;
    px_addr_d = px_addr_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    err_d     = err_q;
    in_range  = (x_q < H_LIM) && (y_q < V_LIM);

    if (state_q == ST_IDLE && cap_req) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end

    if (state_q == ST_WAIT_FS && vs_fall) begin
      x_d    = '0;
      y_d    = '0;
      ph_d   = 1'b0;
      addr_d = BASE;
      line_d = BASE;
    end

    if (state_q == ST_ACTIVE) begin
      if (vs_rise) begin
        done_d = 1'b1;
      end else if (pclk_rise && s_href) begin
        if (!ph_q) begin
          b0_d = s_data;
          ph_d = 1'b1;
        end else begin
          ph_d      = 1'b0;
          px_vld_d  = in_range;
          px_data_d = pix;
          px_addr_d = addr_q;
          if (in_range) addr_d = addr_q + A_ONE;
          if (x_q != 16'hFFFF) x_d = x_q + 16'd1;
        end
      end else if (href_fall) begin
        if (ph_q) err_d = 1'b1;
        ph_d = 1'b0;
        x_d  = '0;
        // restart from the line base so short lines keep geometry
        if (y_q < V_LIM) begin
          y_d    = y_q + 16'd1;
          line_d = line_q + H_STEP;
          addr_d = line_q + H_STEP;
        end
      end
    end

    if (wr_en_q && wr_rdy) wr_en_d = 1'b0;
    if (px_vld_q) begin
      if (!wr_en_q || wr_rdy) begin
        wr_en_d   = 1'b1;
        wr_addr_d = px_addr_q;
        wr_data_d = px_data_q;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q       <= '0;
      y_q       <= '0;
      ph_q      <= 1'b0;
      b0_q      <= '0;
      addr_q    <= BASE;
      line_q    <= BASE;
      px_vld_q  <= 1'b0;
      px_data_q <= '0;
      px_addr_q <= BASE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= BASE;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      ph_q      <= ph_d;
      b0_q      <= b0_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      px_vld_q  <= px_vld_d;
      px_data_q <= px_data_d;
      px_addr_q <= px_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = {8'h00, wr_data_q};
  assign frame_done = done_q;
  assign ovf        = ovf_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cam_dvp_rx.sv
// tb_cam_dvp_rx: directed DVP frames on a 4x4 geometry with
// hand-computed write addresses, data and flag values.
module tb_cam_dvp_rx;

  logic        clk;
  logic        reset;
  logic        cap_req;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        wr_en;
  logic        wr_rdy;
  logic [23:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        frame_done;
  logic        ovf;
  logic        err;
`ifdef CAM_TEST_PATT_EN
  logic        tpat_sel;
`endif

  cam_dvp_rx #(
    .H_ACTIVE  (4),
    .V_ACTIVE  (4),
    .ADDR_W    (24),
    .ADDR_BASE (0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cap_req    (cap_req),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
`ifdef CAM_TEST_PATT_EN
    .tpat_sel   (tpat_sel),
`endif
    .wr_en      (wr_en),
    .wr_rdy     (wr_rdy),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done),
    .ovf        (ovf),
    .err        (err)
  );

  localparam logic [31:0] D_RED   = 32'h00FF0000;
  localparam logic [31:0] D_GREEN = 32'h0000FF00;
  localparam logic [31:0] D_BLUE  = 32'h000000FF;

  int n_vec;
  int n_err;
  int n_done;
  logic [23:0] q_addr[$];
  logic [31:0] q_data[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    #1;
    if (wr_en && wr_rdy) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
    if (frame_done) n_done++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int base,
                        input int idx, input logic [23:0] a,
                        input logic [31:0] d);
    if (base + idx < q_addr.size()) begin
      chk($sformatf("%s_a%0d", tag, idx), q_addr[base+idx], a);
      chk($sformatf("%s_d%0d", tag, idx), q_data[base+idx], d);
    end else begin
      chk($sformatf("%s_n%0d", tag, idx),
          64'(q_addr.size() - base), 64'(idx + 1));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic cam_byte(input logic [7:0] b);
    @(negedge clk);
    cam_data = b;
    cam_href = 1'b1;
    cam_pclk = 1'b0;
    tick(2);
    cam_pclk = 1'b1;
    tick(2);
    cam_pclk = 1'b0;
  endtask

  task automatic cam_pix(input logic [15:0] p);
    cam_byte(p[15:8]);
    cam_byte(p[7:0]);
  endtask

  task automatic cam_line(input int n, input logic [15:0] p);
    for (int i = 0; i < n; i++) cam_pix(p);
  endtask

  task automatic line_end();
    @(negedge clk);
    cam_href = 1'b0;
    tick(8);
  endtask

  task automatic start_frame();
    @(negedge clk);
    cam_vsync = 1'b1;
    tick(8);
    cam_vsync = 1'b0;
    tick(8);
  endtask

  task automatic end_frame();
    @(negedge clk);
    cam_vsync = 1'b1;
    tick(8);
  endtask

  task automatic arm();
    @(negedge clk);
    cap_req = 1'b1;
    @(negedge clk);
    cap_req = 1'b0;
  endtask

  int b0;
  int d0;

  initial begin
    n_vec = 0;
    n_err = 0;
    n_done = 0;
    reset = 1'b1;
    cap_req = 1'b0;
    cam_pclk = 1'b0;
    cam_vsync = 1'b1;
    cam_href = 1'b0;
    cam_data = 8'h00;
    wr_rdy = 1'b1;
`ifdef CAM_TEST_PATT_EN
    tpat_sel = 1'b0;
`endif
    tick(3);
    reset = 1'b0;
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_err", err, 0);

    // full 4x4 frame of pure red
    b0 = q_addr.size();
    d0 = n_done;
    arm();
    settle(2);
    chk("a_busy_armed", busy, 1);
    start_frame();
    for (int l = 0; l < 4; l++) begin
      cam_line(4, 16'hF800);
      line_end();
    end
    end_frame();
    settle(2);
    chk("a_count", q_addr.size() - b0, 16);
    for (int i = 0; i < 16; i++)
      chk_wr("a", b0, i, 24'(i), D_RED);
    chk("a_done", n_done - d0, 1);
    chk("a_busy", busy, 0);
    chk("a_ovf", ovf, 0);
    chk("a_err", err, 0);

    // cap_req while a frame is already running
    b0 = q_addr.size();
    @(negedge clk);
    cam_vsync = 1'b0;
    tick(8);
    cam_line(4, 16'hF800);
    line_end();
    arm();
    cam_line(4, 16'hF800);
    line_end();
    settle(1);
    chk("b_nowr", q_addr.size() - b0, 0);
    chk("b_busy", busy, 1);
    end_frame();
    start_frame();
    cam_line(4, 16'h07E0);
    line_end();
    end_frame();
    settle(2);
    chk("b_count", q_addr.size() - b0, 4);
    for (int i = 0; i < 4; i++)
      chk_wr("b", b0, i, 24'(i), D_GREEN);

    // backpressure: pixel 0 held, pixels 1 and 2 dropped
    b0 = q_addr.size();
    arm();
    @(negedge clk);
    wr_rdy = 1'b0;
    start_frame();
    cam_line(3, 16'h07E0);
    settle(6);
    chk("c_hold_en", wr_en, 1);
    chk("c_hold_addr", wr_addr, 0);
    chk("c_hold_data", wr_data, D_GREEN);
    chk("c_ovf", ovf, 1);
    chk("c_nowr", q_addr.size() - b0, 0);
    @(negedge clk);
    wr_rdy = 1'b1;
    tick(2);
    cam_pix(16'hF800);
    line_end();
    end_frame();
    settle(2);
    chk("c_count", q_addr.size() - b0, 2);
    chk_wr("c", b0, 0, 24'd0, D_GREEN);
    chk_wr("c", b0, 1, 24'd3, D_RED);

    // odd byte count on line 0
    b0 = q_addr.size();
    arm();
    settle(1);
    chk("d_ovf_clr", ovf, 0);
    start_frame();
    cam_line(4, 16'hF800);
    cam_byte(8'hF8);
    line_end();
    settle(1);
    chk("d_err", err, 1);
    cam_line(4, 16'h001F);
    line_end();
    end_frame();
    settle(2);
    chk("d_count", q_addr.size() - b0, 8);
    for (int i = 0; i < 4; i++)
      chk_wr("d0", b0, i, 24'(i), D_RED);
    for (int i = 4; i < 8; i++)
      chk_wr("d1", b0, i, 24'(i), D_BLUE);

    // 6-pixel line, only the first 4 stored
    b0 = q_addr.size();
    arm();
    settle(1);
    chk("e_err_clr", err, 0);
    start_frame();
    cam_line(6, 16'hF800);
    line_end();
    cam_line(4, 16'h07E0);
    line_end();
    end_frame();
    settle(2);
    chk("e_count", q_addr.size() - b0, 8);
    for (int i = 0; i < 4; i++)
      chk_wr("e0", b0, i, 24'(i), D_RED);
    for (int i = 4; i < 8; i++)
      chk_wr("e1", b0, i, 24'(i), D_GREEN);

    // reset mid-frame with a pending write
    b0 = q_addr.size();
    arm();
    @(negedge clk);
    wr_rdy = 1'b0;
    start_frame();
    cam_line(2, 16'h001F);
    settle(6);
    chk("f_pend", wr_en, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("f_rst_en", wr_en, 0);
    chk("f_rst_busy", busy, 0);
    chk("f_rst_addr", wr_addr, 0);
    @(negedge clk);
    reset = 1'b0;
    wr_rdy = 1'b1;
    cam_line(2, 16'h001F);
    line_end();
    end_frame();
    settle(2);
    chk("f_nowr", q_addr.size() - b0, 0);
    arm();
    start_frame();
    cam_line(4, 16'hF800);
    line_end();
    end_frame();
    settle(2);
    chk("f_count", q_addr.size() - b0, 4);
    for (int i = 0; i < 4; i++)
      chk_wr("f", b0, i, 24'(i), D_RED);
    chk("f_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
